// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK poller: FSM states, frame length,
// the centre value that means "no motion", and the LED command prefix.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } jstk_state_e;

    localparam int         JSTK_NBYTES     = 5;
    localparam logic [9:0] JSTK_CENTER     = 10'd512;
    localparam logic [5:0] JSTK_LED_PREFIX = 6'b100000;

endpackage

// File: rtl/spi_byte_xfer.sv
// SPI mode-0 single-byte shifter: MSB first, miso sampled as sclk rises,
// mosi advanced as sclk falls, done pulses combinationally on the 16th sclk toggle.
module spi_byte_xfer #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [3:0]    edge_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          div_end;

    assign div_end = (div_cnt == DIV_LAST);
    // Asserted in the last cycle of the byte so the caller can change state on the same edge.
    assign done    = active && div_end && (edge_cnt == 4'd15);
    assign mosi    = tx_sr[7];
    assign rx_byte = rx_sr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= 4'd0;
            sclk     <= 1'b0;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
        end else if (start) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= 4'd0;
            sclk     <= 1'b0;
            tx_sr    <= tx_byte;
        end else if (active) begin
            if (div_end) begin
                div_cnt  <= '0;
                sclk     <= ~sclk;
                edge_cnt <= edge_cnt + 4'd1;
                if (!sclk) begin
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
                if (edge_cnt == 4'd15) begin
                    active <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmod_jstk_reader.sv
// Periodic PmodJSTK poller: five-byte SPI frame, outputs updated atomically in DONE.
// Define JSTK_LED_CMD_EN to send the led bits in byte 0; otherwise byte 0 is 0x00.
module pmod_jstk_reader #(
    parameter int CLK_DIV           = 50,
    parameter int SS_SETUP_CYCLES   = 1500,
    parameter int INTER_BYTE_CYCLES = 1000,
    parameter int POLL_CYCLES       = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       miso,
    input  logic [1:0] led,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       valid,
    output logic       busy
);
    import jstk_pkg::*;

    localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] SETUP_LAST = 32'(SS_SETUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(INTER_BYTE_CYCLES - 1);
    localparam logic [2:0]  LAST_BYTE  = 3'(JSTK_NBYTES - 1);

    jstk_state_e state;
    logic [31:0] cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  x_lo, y_lo;
    logic [1:0]  x_hi, y_hi;
    logic [7:0]  tx_byte, byte0, rx_byte;
    logic        start, xfer_done;

`ifdef JSTK_LED_CMD_EN
    logic [1:0] led_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            led_q <= 2'b00;
        end else if (state == ST_IDLE && cnt == POLL_LAST) begin
            led_q <= led;
        end
    end

    assign byte0 = {JSTK_LED_PREFIX, led_q};
`else
    logic unused_led;
    assign unused_led = ^led;
    assign byte0      = 8'h00;
`endif

    assign tx_byte = (byte_idx == 3'd0) ? byte0 : 8'h00;
    assign start   = (state == ST_SETUP && cnt == SETUP_LAST) ||
                     (state == ST_GAP   && cnt == GAP_LAST);

    spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_byte (rx_byte),
        .done    (xfer_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            cnt      <= 32'd0;
            byte_idx <= 3'd0;
            ss_n     <= 1'b1;
            busy     <= 1'b0;
            valid    <= 1'b0;
            joy_x    <= JSTK_CENTER;
            joy_y    <= JSTK_CENTER;
            btn      <= 3'b000;
            x_lo     <= 8'h00;
            x_hi     <= 2'b00;
            y_lo     <= 8'h00;
            y_hi     <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cnt == POLL_LAST) begin
                        state    <= ST_SETUP;
                        cnt      <= 32'd0;
                        byte_idx <= 3'd0;
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_SETUP, ST_GAP: begin
                    if (start) begin
                        state <= ST_SHIFT;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_SHIFT: begin
                    if (xfer_done) begin
                        case (byte_idx)
                            3'd0:    x_lo <= rx_byte;
                            3'd1:    x_hi <= rx_byte[1:0];
                            3'd2:    y_lo <= rx_byte;
                            3'd3:    y_hi <= rx_byte[1:0];
                            default: ;
                        endcase
                        // Last byte goes straight to btn; everything publishes on this edge.
                        if (byte_idx == LAST_BYTE) begin
                            state <= ST_DONE;
                            ss_n  <= 1'b1;
                            valid <= 1'b1;
                            joy_x <= {x_hi, x_lo};
                            joy_y <= {y_hi, y_lo};
                            btn   <= rx_byte[2:0];
                        end else begin
                            state    <= ST_GAP;
                            cnt      <= 32'd0;
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= 32'd0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_jstk_reader.sv
// Bench for pmod_jstk_reader: behavioural SPI slave feeding randomised frames,
// decoded values and timing compared against arithmetic expectations.
module tb_pmod_jstk_reader;

    localparam int CLK_DIV = 2;
    localparam int SS      = 4;
    localparam int GAP     = 3;
    localparam int POLL    = 20;
    localparam int T       = SS + 80*CLK_DIV + 4*GAP + 1;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] led = 2'b00;
    logic       miso;
    logic       ss_n, sclk, mosi, valid, busy;
    logic [9:0] joy_x, joy_y;
    logic [2:0] btn;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int valid_cnt = 0;

    pmod_jstk_reader #(
        .CLK_DIV(CLK_DIV), .SS_SETUP_CYCLES(SS),
        .INTER_BYTE_CYCLES(GAP), .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk), .clr(clr), .miso(miso), .led(led),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
        .joy_x(joy_x), .joy_y(joy_y), .btn(btn),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid === 1'b1) valid_cnt <= valid_cnt + 1;

    // Behavioural joystick: shifts out the 40-bit frame captured when ss_n falls.
    logic [39:0] frame;
    logic [39:0] frame_q    = 40'd0;
    int          fall_total = 0, fall_base = 0;
    int          rise_total = 0, rise_base = 0;
    logic [39:0] mosi_bits  = 40'd0;
    int          idx, rise_cnt;
    logic [5:0]  sel;

    always @(negedge ss_n) begin
        frame_q   = frame;
        fall_base = fall_total;
        rise_base = rise_total;
    end
    always @(negedge sclk) fall_total = fall_total + 1;
    always @(posedge sclk) begin
        if (ss_n === 1'b0) begin
            rise_total = rise_total + 1;
            mosi_bits  = {mosi_bits[38:0], mosi};
        end
    end

    assign idx      = fall_total - fall_base;
    assign rise_cnt = rise_total - rise_base;
    assign sel      = (idx >= 0 && idx < 40) ? 6'(39 - idx) : 6'd0;
    assign miso     = (idx >= 0 && idx < 40) ? frame_q[sel] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge where valid is high; f is the frame, l the led value used.
    task automatic check_txn(input string tag, input logic [39:0] f, input logic [1:0] l);
        int b[5];
        int ex, ey, eb, e0;
        for (int k = 0; k < 5; k++) b[k] = int'(f[39-8*k -: 8]);
        ex = (b[1] % 4) * 256 + b[0];
        ey = (b[3] % 4) * 256 + b[2];
        eb = b[4] % 8;
`ifdef JSTK_LED_CMD_EN
        e0 = 128 + int'(l);
`else
        e0 = 0 * int'(l);
`endif
        chk({tag, "_joy_x"}, 32'(joy_x), 32'(ex));
        chk({tag, "_joy_y"}, 32'(joy_y), 32'(ey));
        chk({tag, "_btn"},   32'(btn),   32'(eb));
        chk({tag, "_sclk_rises"}, 32'(rise_cnt), 32'd40);
        chk({tag, "_mosi_byte0"}, 32'(mosi_bits[39:32]), 32'(e0));
        chk({tag, "_mosi_rest"},  32'(mosi_bits[31:0]), 32'd0);
        chk({tag, "_ss_n_done"},  32'(ss_n), 32'd1);
        chk({tag, "_busy_done"},  32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
        chk({tag, "_busy_idle"},  32'(busy),  32'd0);
        chk({tag, "_hold_x"},     32'(joy_x), 32'(ex));
        $display("txn %s frame=%010h led=%0d joy_x=%0d joy_y=%0d btn=%0d",
                 tag, f, l, joy_x, joy_y, btn);
    endtask

    initial begin
        bit ok;
        bit ss_high;
        int t_prev, vc0, t_rel;

        frame = 40'h34_02_CD_01_05;
        led   = 2'b11;
        repeat (3) @(negedge clk);
        clr = 1'b0;

        chk("rst_joy_x", 32'(joy_x), 32'd512);
        chk("rst_joy_y", 32'(joy_y), 32'd512);
        chk("rst_btn",   32'(btn),   32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ss_n",  32'(ss_n),  32'd1);
        chk("rst_sclk",  32'(sclk),  32'd0);
        chk("rst_mosi",  32'(mosi),  32'd0);

        ss_high = 1'b1;
        for (int i = 0; i < POLL - 1; i++) begin
            @(negedge clk);
            if (ss_n !== 1'b1 || joy_x !== 10'd512) ss_high = 1'b0;
        end
        chk("poll_ss_n_held", 32'(ss_high), 32'd1);
        @(negedge clk);
        chk("poll_ss_n_fall", 32'(ss_n), 32'd0);
        chk("poll_busy", 32'(busy), 32'd1);

        wait_valid(T + 10, ok);
        chk("basic_valid_seen", 32'(ok), 32'd1);
        t_prev = cyc;
        check_txn("basic", frame, led);
        chk("basic_valid_count", 32'(valid_cnt), 32'd1);

        frame = 40'hFF_FE_00_FC_F8;
        wait_valid(POLL + T + 10, ok);
        chk("upper_valid_seen", 32'(ok), 32'd1);
        chk("upper_period", 32'(cyc - t_prev), 32'(POLL + T));
        t_prev = cyc;
        check_txn("upper", frame, led);

        for (int r = 0; r < 4; r++) begin
            frame = {8'($urandom), $urandom};
            led   = 2'($urandom_range(0, 3));
            wait_valid(POLL + T + 10, ok);
            chk("rand_valid_seen", 32'(ok), 32'd1);
            chk("rand_period", 32'(cyc - t_prev), 32'(POLL + T));
            t_prev = cyc;
            check_txn("rand", frame, led);
        end

        // Abort in the middle of byte 2.
        ok = 1'b0;
        for (int i = 0; i < POLL + T + 10; i++) begin
            @(negedge clk);
            if (ss_n === 1'b0 && rise_cnt >= 19) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reached_byte2", 32'(ok), 32'd1);
        vc0 = valid_cnt;
        clr = 1'b1;
        #1;
        chk("mid_ss_n",  32'(ss_n),  32'd1);
        chk("mid_sclk",  32'(sclk),  32'd0);
        chk("mid_joy_x", 32'(joy_x), 32'd512);
        chk("mid_joy_y", 32'(joy_y), 32'd512);
        chk("mid_btn",   32'(btn),   32'd0);
        chk("mid_busy",  32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        chk("mid_no_valid", 32'(valid_cnt), 32'(vc0));
        frame = {8'($urandom), $urandom};
        clr   = 1'b0;
        t_rel = cyc;
        wait_valid(POLL + T + 10, ok);
        chk("post_valid_seen", 32'(ok), 32'd1);
        chk("post_latency", 32'(cyc - t_rel), 32'(POLL + T - 1));
        check_txn("post", frame, led);
        chk("post_valid_count", 32'(valid_cnt), 32'(vc0 + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
